// File: rtl/cdc_tx.sv
// cdc_tx: transmit half of a 4-phase request/acknowledge CDC handshake.
// Upstream words arrive on a valid/ready interface. Each accepted word is
// captured into o_dat and held stable while o_vld/o_rdy complete a full
// 4-phase round trip. The acknowledge comes in asynchronously from the peer
// domain and passes through a SYNC_DP-deep synchroniser before any logic
// uses it. An acknowledge seen while idle latches a sticky error flag.
module cdc_tx #(
  parameter int DW      = 32,
  parameter int SYNC_DP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_DP-1:0] sync_q;
  logic               rdy_s;

  logic               o_vld_nxt;
  logic               load;
  logic               err_set;
  logic               accept;

  // Shift the asynchronous acknowledge through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DP-2:0], o_rdy};
    end
  end

  assign rdy_s = sync_q[SYNC_DP-1];

  // Ready only when idle with the previous acknowledge seen low; held low in reset.
  assign i_rdy  = (state == IDLE) && !rdy_s && !rst;
  assign accept = i_vld && i_rdy;

  // Next-state and next-request decode for the 4-phase sequence.
  always_comb begin
    state_nxt = state;
    o_vld_nxt = o_vld;
    load      = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy_s) begin
          err_set = 1'b1;
        end else if (accept) begin
          load      = 1'b1;
          o_vld_nxt = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rdy_s) begin
          o_vld_nxt = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!rdy_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        o_vld_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus the registered request so o_vld is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      o_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      o_vld <= o_vld_nxt;
    end
  end

  // Capture the data word only on an accept; it stays put until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dat <= '0;
    end else if (load) begin
      o_dat <= i_dat;
    end
  end

  // Sticky error on an acknowledge that arrives with no request outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_tx.sv
// tb_cdc_tx: scenario-driven bench for cdc_tx with a data scoreboard.
module tb_cdc_tx;

  localparam int DW      = 32;
  localparam int SYNC_DP = 2;

  logic          clk;
  logic          rst;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [SYNC_DP-1:0] mdl_sync;

  cdc_tx #(.DW(DW), .SYNC_DP(SYNC_DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .err   (err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference view of the synchronised acknowledge.
  always @(posedge clk or posedge rst) begin
    if (rst) mdl_sync <= '0;
    else     mdl_sync <= {mdl_sync[SYNC_DP-2:0], o_rdy};
  end

  // Hard stop in case something hangs.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; o_rdy = 1'b0; i_vld = 1'b0; i_dat = '0;
    repeat (3) tick();
    checks++;
    if (i_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_irdy_held: got %b expected 0", i_rdy); end
    rst = 1'b0;
    #1;
    checks++;
    if (o_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovld: got %b expected 0", o_vld); end
    checks++;
    if (o_dat !== '0) begin failures++; $display("[TB] FAIL reset_odat: got %h expected 0", o_dat); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++;
    if (i_rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_irdy_after: got %b expected 1", i_rdy); end
  endtask

  task automatic test_single(input logic [DW-1:0] word);
    logic [DW-1:0] exp;
    bit found;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (i_rdy === 1'b1) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL single_wait_irdy: got %b expected 1", i_rdy); end
    i_vld = 1'b1; i_dat = word; exp_q.push_back(word);
    tick();
    i_vld = 1'b0; i_dat = DW'($urandom);
    checks++;
    if (o_vld !== 1'b1) begin failures++; $display("[TB] FAIL single_ovld_rise: got %b expected 1", o_vld); end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("[TB] FAIL single_scoreboard_empty: got %h expected none", o_dat);
    end else begin
      exp = exp_q.pop_front();
      if (o_dat !== exp) begin failures++; $display("[TB] FAIL single_odat: got %h expected %h", o_dat, exp); end
    end
    tick();
    checks++;
    if (o_vld !== 1'b1 || i_rdy !== 1'b0) begin
      failures++; $display("[TB] FAIL single_req_hold: got vld=%b rdy=%b expected vld=1 rdy=0", o_vld, i_rdy);
    end
    o_rdy = 1'b1;
    for (int k = 1; k <= SYNC_DP + 1; k++) begin
      tick();
      checks++;
      if (o_vld !== (k < SYNC_DP + 1)) begin
        failures++; $display("[TB] FAIL single_ovld_fall_edge%0d: got %b expected %b", k, o_vld, (k < SYNC_DP + 1));
      end
      checks++;
      if (o_dat !== word) begin failures++; $display("[TB] FAIL single_odat_ack: got %h expected %h", o_dat, word); end
    end
    tick();
    o_rdy = 1'b0;
    found = 0;
    for (int k = 1; k <= SYNC_DP + 1; k++) begin
      tick();
      checks++;
      if (o_dat !== word || o_vld !== 1'b0) begin
        failures++; $display("[TB] FAIL single_release: got vld=%b dat=%h expected vld=0 dat=%h", o_vld, o_dat, word);
      end
      if (i_rdy === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL single_irdy_return: got %b expected 1", i_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    int idx;
    int received;
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
    idx = 0; received = 0;
    fork
      begin : driver
        logic acc;
        i_vld = 1'b1; i_dat = words[0];
        for (int c = 0; c < 300 && idx < 3; c++) begin
          acc = i_rdy;
          if (acc) exp_q.push_back(i_dat);
          tick();
          if (acc) begin
            idx++;
            if (idx < 3) i_dat = words[idx];
          end
        end
        i_vld = 1'b0;
      end
      begin : peer
        bit got;
        logic [DW-1:0] exp;
        for (int n = 0; n < 3; n++) begin
          got = 0;
          for (int c = 0; c < 100; c++) begin
            if (o_vld === 1'b1) begin got = 1; break; end
            tick();
          end
          checks++;
          if (!got) begin failures++; $display("[TB] FAIL b2b_req_timeout: got %b expected 1", o_vld); break; end
          checks++;
          if (mdl_sync[SYNC_DP-1] !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_vld_over_ack: got rdy_s=%b expected 0", mdl_sync[SYNC_DP-1]);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL b2b_scoreboard_empty: got %h expected none", o_dat);
          end else begin
            exp = exp_q.pop_front();
            if (o_dat !== exp) begin failures++; $display("[TB] FAIL b2b_odat: got %h expected %h", o_dat, exp); end
          end
          checks++;
          if (o_dat !== words[n]) begin failures++; $display("[TB] FAIL b2b_order%0d: got %h expected %h", n, o_dat, words[n]); end
          received++;
          repeat ($urandom_range(0, 3)) tick();
          o_rdy = 1'b1;
          got = 0;
          for (int c = 0; c < 100; c++) begin
            if (o_vld === 1'b0) begin got = 1; break; end
            tick();
          end
          checks++;
          if (!got) begin failures++; $display("[TB] FAIL b2b_release_timeout: got %b expected 0", o_vld); end
          o_rdy = 1'b0;
          tick();
        end
      end
    join
    checks++;
    if (idx != 3 || received != 3) begin
      failures++; $display("[TB] FAIL b2b_count: got sent=%0d recv=%0d expected 3/3", idx, received);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_slow_peer();
    logic [DW-1:0] word;
    logic [DW-1:0] exp;
    bit found;
    word = 32'h13572468;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (i_rdy === 1'b1) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL slow_wait_irdy: got %b expected 1", i_rdy); end
    i_vld = 1'b1; i_dat = word; exp_q.push_back(word);
    tick();
    checks++;
    exp = exp_q.pop_front();
    if (o_vld !== 1'b1 || o_dat !== exp) begin
      failures++; $display("[TB] FAIL slow_req: got vld=%b dat=%h expected vld=1 dat=%h", o_vld, o_dat, exp);
    end
    for (int c = 0; c < 50; c++) begin
      i_vld = 1'($urandom); i_dat = DW'($urandom);
      tick();
      checks++;
      if (o_vld !== 1'b1 || i_rdy !== 1'b0 || o_dat !== word) begin
        failures++;
        $display("[TB] FAIL slow_hold_c%0d: got vld=%b rdy=%b dat=%h expected vld=1 rdy=0 dat=%h", c, o_vld, i_rdy, o_dat, word);
      end
    end
    i_vld = 1'b0;
    o_rdy = 1'b1;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_vld === 1'b0) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL slow_release: got %b expected 0", o_vld); end
    o_rdy = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (i_rdy === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found || o_dat !== word) begin
      failures++; $display("[TB] FAIL slow_idle: got rdy=%b dat=%h expected rdy=1 dat=%h", i_rdy, o_dat, word);
    end
  endtask

  task automatic test_unsolicited_ack();
    bit found;
    checks++;
    if (i_rdy !== 1'b1 || err !== 1'b0) begin
      failures++; $display("[TB] FAIL ack_pre: got rdy=%b err=%b expected rdy=1 err=0", i_rdy, err);
    end
    o_rdy = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL ack_err_early: got %b expected 0", err); end
    tick();
    checks++;
    if (i_rdy !== 1'b0) begin failures++; $display("[TB] FAIL ack_irdy_low: got %b expected 0", i_rdy); end
    i_vld = 1'b1; i_dat = 32'h0BADF00D;
    tick();
    checks++;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL ack_err_set: got %b expected 1", err); end
    checks++;
    if (o_vld !== 1'b0 || i_rdy !== 1'b0) begin
      failures++; $display("[TB] FAIL ack_no_accept: got vld=%b rdy=%b expected vld=0 rdy=0", o_vld, i_rdy);
    end
    tick();
    checks++;
    if (o_vld !== 1'b0 || i_rdy !== 1'b0) begin
      failures++; $display("[TB] FAIL ack_no_accept2: got vld=%b rdy=%b expected vld=0 rdy=0", o_vld, i_rdy);
    end
    o_rdy = 1'b0; i_vld = 1'b0;
    found = 0;
    for (int c = 0; c < SYNC_DP + 2; c++) begin
      tick();
      checks++;
      if (o_vld !== 1'b0) begin failures++; $display("[TB] FAIL ack_vld_spurious: got %b expected 0", o_vld); end
      if (i_rdy === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL ack_irdy_return: got %b expected 1", i_rdy); end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL ack_err_sticky: got %b expected 1", err); end
    test_single(32'h2468ACE0);
    checks++;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL ack_err_after_xfer: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid_req();
    logic [DW-1:0] exp;
    i_vld = 1'b1; i_dat = 32'hA5A5A5A5; exp_q.push_back(32'hA5A5A5A5);
    tick();
    i_vld = 1'b0;
    checks++;
    exp = exp_q.pop_front();
    if (o_vld !== 1'b1 || o_dat !== exp) begin
      failures++; $display("[TB] FAIL midreq_req: got vld=%b dat=%h expected vld=1 dat=%h", o_vld, o_dat, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_vld !== 1'b0) begin failures++; $display("[TB] FAIL midreq_ovld_async: got %b expected 0", o_vld); end
    checks++;
    if (o_dat !== '0) begin failures++; $display("[TB] FAIL midreq_odat_async: got %h expected 0", o_dat); end
    checks++;
    if (err !== 1'b0 || i_rdy !== 1'b0) begin
      failures++; $display("[TB] FAIL midreq_err_irdy: got err=%b rdy=%b expected err=0 rdy=0", err, i_rdy);
    end
    exp_q.delete();
    tick();
    tick();
    o_rdy = 1'b0;
    rst = 1'b0;
    #1;
    test_single(32'h5A5A5A5A);
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1; i_vld = 1'b0; i_dat = '0; o_rdy = 1'b0;
    test_reset();
    test_single(32'hDEADBEEF);
    test_back_to_back();
    test_slow_peer();
    test_unsolicited_ack();
    test_reset_mid_req();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
